register_reader: RTL and testbench
==================================

REGISTER_READER -- requirements
Module: register_reader

Interface
REQ-001 Parameter NumRegs, default 16, number of 8-bit registers held.
REQ-002 Parameter IndexWidth, default $clog2(NumRegs), register index width.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstN  input  1  synchronous active-low reset.
REQ-006 writeEn  input  1  write strobe; writes regs[writeAddr] on this edge.
REQ-007 writeAddr  input  IndexWidth  write index.
REQ-008 writeData  input  8  write data.
REQ-009 readReq  input  1  single-register read request, sampled in IDLE only.
REQ-010 readAddr  input  IndexWidth  single-read index, captured with readReq.
REQ-011 dumpReq  input  1  full-file dump request, sampled in IDLE only.
REQ-012 outValid  output  1  output beat valid.
REQ-013 outReady  input  1  sink accepts beat when outValid and outReady are both high.
REQ-014 outData  output  8  beat data.
REQ-015 outAddr  output  IndexWidth  index of beat data.
REQ-016 outLast  output  1  final beat of current transaction.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, SINGLE, DUMP.
REQ-019 In IDLE, dumpReq=1 SHALL go to DUMP with index 0; otherwise readReq=1 SHALL go to SINGLE with index readAddr; dumpReq wins when both are high.
REQ-020 A beat SHALL be loaded into the output holding registers on the edge that enters SINGLE/DUMP, so outValid rises exactly 1 cycle after the request.
REQ-021 outData, outAddr and outLast SHALL stay stable while outValid=1 and outReady=0.
REQ-022 SINGLE: outLast=1; on handshake, return to IDLE with outValid=0.
REQ-023 DUMP: beats SHALL be emitted for indices 0..NumRegs-1 in order; outLast=1 only on index NumRegs-1.
REQ-024 DUMP: on a non-last handshake, load index+1 on the same edge with no bubble (back-to-back beats when outReady is held high).
REQ-025 DUMP: on the last-beat handshake, return to IDLE; the index SHALL NOT wrap.
REQ-026 readReq and dumpReq SHALL be ignored while busy=1; they are not queued.
REQ-027 Writes SHALL be accepted in every state.
REQ-028 If a write hits the index being loaded on the same edge, the loaded beat SHALL carry the new writeData (write-first bypass).
REQ-029 A write to an already-loaded beat's index SHALL NOT alter that held beat.
REQ-030 A new request in IDLE on the cycle after returning to IDLE SHALL be honoured.

Reset
REQ-031 With rstN=0 at a clock edge: all regs=0, state=IDLE, index=0, outValid=0, outData=0, outAddr=0, outLast=0, busy=0.
REQ-032 Reset mid-transaction SHALL abort it with no further beats; writes on a reset edge are discarded.

Configuration
REQ-033 Macro REGISTER_READER_PARITY_EN defined: add output port outParity (1 bit) = even parity (XOR) of outData, registered with the beat and reset to 0.
REQ-034 Macro REGISTER_READER_PARITY_EN undefined: outParity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Shared package register_pkg SHALL hold the DATA_WIDTH=8 constant and the reader_state_e enum (IDLE, SINGLE, DUMP).
REQ-036 Storage SHALL be sub-module register_storage: NumRegs x 8 array, synchronous write port, combinational read port, synchronous reset to 0.

Verification
REQ-037 Write 0xA5 to reg 3, readReq with readAddr=3, outReady=1 -> outValid=1 one cycle later; outData=0xA5, outAddr=3, outLast=1; busy=0 the cycle after.
REQ-038 Write regs[i]=i+0x10 for all i, dumpReq, outReady=1 -> 16 consecutive beats 0x10..0x1F; outLast on addr 15 only; then IDLE.
REQ-039 Dump with outReady toggling 1,0,0,1 and writeAddr=5/writeData=0xFF issued while beat 5 is stalled -> beats held stable, beat 5 keeps its old value, no beat lost or duplicated.
REQ-040 dumpReq and readReq in the same cycle -> dump performed; readReq during the dump is ignored; no SINGLE beat follows.
REQ-041 rstN=0 asserted during beat 7 of a dump -> next cycle outValid=0, busy=0, reg 2 previously 0x33 now reads 0x00.
REQ-042 Same-edge writeAddr=0/writeData=0x5A with dumpReq -> first beat outData=0x5A; with REGISTER_READER_PARITY_EN defined, outParity=0.

Source files
------------

// File: rtl/register_pkg.sv
// Shared constants and types for the register reader slice.
package register_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    DUMP   = 2'd2
  } reader_state_e;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] dat);
    return ^dat;
  endfunction

endpackage

// File: rtl/register_storage.sv
// NumRegs x DATA_WIDTH register array: synchronous write, combinational read, 0 latency.
// No backpressure; reset clears every entry and drops a coincident write.
module register_storage
  import register_pkg::*;
#(
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en_i,
  input  logic [IndexWidth-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic [IndexWidth-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (int'(wr_addr_i) < NumRegs)) begin
      regs_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Indices past the array (non power-of-two NumRegs) read as zero.
  assign rd_dat_o = (int'(rd_addr_i) < NumRegs) ? regs_q[rd_addr_i] : '0;

endmodule

// File: rtl/register_reader.sv
// Register file reader: single reads and full dumps as valid/ready beats, outValid 1 cycle after request.
// Beats hold while outReady is low; requests ignored while busy. REGISTER_READER_PARITY_EN adds outParity.
module register_reader
  import register_pkg::*;
#(
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  writeEn,
  input  logic [IndexWidth-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  readReq,
  input  logic [IndexWidth-1:0] readAddr,
  input  logic                  dumpReq,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [IndexWidth-1:0] outAddr,
  output logic                  outLast,
`ifdef REGISTER_READER_PARITY_EN
  output logic                  outParity,
`endif
  output logic                  busy
);

  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

  reader_state_e         state_q, state_d;
  logic [IndexWidth-1:0] idx_q, idx_d, load_idx;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic [DATA_WIDTH-1:0] rd_dat, load_dat;
  logic                  load, load_single, handshake;

  register_storage #(
    .NumRegs   (NumRegs),
    .IndexWidth(IndexWidth)
  ) u_storage (
    .clk      (clk),
    .rstN     (rstN),
    .wr_en_i  (writeEn),
    .wr_addr_i(writeAddr),
    .wr_dat_i (writeData),
    .rd_addr_i(load_idx),
    .rd_dat_o (rd_dat)
  );

  assign handshake = out_vld_q & outReady;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    load_single = 1'b0;
    load_idx    = idx_q;

    unique case (state_q)
      IDLE: begin
        if (dumpReq) begin
          state_d  = DUMP;
          load     = 1'b1;
          load_idx = '0;
        end else if (readReq) begin
          state_d     = SINGLE;
          load        = 1'b1;
          load_single = 1'b1;
          load_idx    = readAddr;
        end
      end
      SINGLE: begin
        if (handshake) begin
          state_d   = IDLE;
          out_vld_d = 1'b0;
        end
      end
      DUMP: begin
        if (handshake) begin
          if (out_last_q) begin
            state_d   = IDLE;
            out_vld_d = 1'b0;
          end else begin
            load     = 1'b1;
            load_idx = idx_q + IndexWidth'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        out_vld_d = 1'b0;
      end
    endcase

    if (load) begin
      idx_d      = load_idx;
      out_vld_d  = 1'b1;
      out_last_d = load_single | (load_idx == LastIdx);
    end
  end

  // A write landing on the index being loaded this edge is forwarded into the beat.
  assign load_dat  = (writeEn && (writeAddr == load_idx)) ? writeData : rd_dat;
  assign out_dat_d = load ? load_dat : out_dat_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_dat_q  <= out_dat_d;
    end
  end

`ifdef REGISTER_READER_PARITY_EN
  logic out_par_q, out_par_d;

  assign out_par_d = load ? even_parity(load_dat) : out_par_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign outParity = out_par_q;
`endif

  assign outValid = out_vld_q;
  assign outData  = out_dat_q;
  assign outAddr  = idx_q;
  assign outLast  = out_last_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_register_reader.sv
// Directed bench for register_reader: inputs driven and outputs sampled on the falling edge.
module tb_register_reader;
  import register_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          writeEn;
  logic [IW-1:0] writeAddr;
  logic [7:0]    writeData;
  logic          readReq;
  logic [IW-1:0] readAddr;
  logic          dumpReq;
  logic          outValid;
  logic          outReady;
  logic [7:0]    outData;
  logic [IW-1:0] outAddr;
  logic          outLast;
  logic          busy;
`ifdef REGISTER_READER_PARITY_EN
  logic          outParity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  register_reader #(.NumRegs(N), .IndexWidth(IW)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .writeEn  (writeEn),
    .writeAddr(writeAddr),
    .writeData(writeData),
    .readReq  (readReq),
    .readAddr (readAddr),
    .dumpReq  (dumpReq),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outAddr  (outAddr),
    .outLast  (outLast),
`ifdef REGISTER_READER_PARITY_EN
    .outParity(outParity),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstN = 1'b0; writeEn = 1'b0; writeAddr = '0; writeData = '0;
    readReq = 1'b0; readAddr = '0; dumpReq = 1'b0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({outValid, busy, outLast} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: valid/busy/last=%b required 000", {outValid, busy, outLast});
    end
    n_checks++;
    if ({outData, outAddr} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_beat: data=%h addr=%h required 00/0", outData, outAddr);
    end
    rstN = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    writeEn = 1'b1; writeAddr = 4'd3; writeData = 8'hA5;
    @(negedge clk);
    writeEn = 1'b0; readReq = 1'b1; readAddr = 4'd3; outReady = 1'b1;
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pre: outValid=%b required 0", outValid);
    end
    @(negedge clk);
    readReq = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr, outLast, busy} !== {1'b1, 8'hA5, 4'd3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_beat: v=%b d=%h a=%h l=%b b=%b required 1 a5 3 1 1",
               outValid, outData, outAddr, outLast, busy);
    end
`ifdef REGISTER_READER_PARITY_EN
    n_checks++;
    if (outParity !== 1'b0) begin
      n_fail++;
      $display("FAIL single_parity: %b required 0", outParity);
    end
`endif
    @(negedge clk);
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: valid/busy=%b required 00", {outValid, busy});
    end
  endtask

  task automatic test_dump();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      writeEn = 1'b1; writeAddr = 4'(i); writeData = 8'(8'h10 + i);
    end
    @(negedge clk);
    writeEn = 1'b0; dumpReq = 1'b1; outReady = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({outValid, outData, outAddr, outLast} !== {1'b1, 8'(8'h10 + i), 4'(i), (i == N - 1)}) begin
        n_fail++;
        $display("FAIL dump_beat%0d: v=%b d=%h a=%h l=%b", i, outValid, outData, outAddr, outLast);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL dump_done: valid/busy=%b required 00", {outValid, busy});
    end
  endtask

  task automatic test_stall();
    logic [3:0]    pat = 4'b1001;
    logic          r;
    logic          have_prev = 1'b0;
    logic [7:0]    prev_dat = '0;
    logic [IW-1:0] prev_addr = '0;
    logic          prev_last = 1'b0;
    int            nbeats = 0;
    int            stall5 = 0;
    @(negedge clk);
    dumpReq = 1'b1; outReady = 1'b0;
    @(negedge clk);
    dumpReq = 1'b0;
    for (int cyc = 0; cyc < 200 && nbeats < N; cyc++) begin
      writeEn = 1'b0;
      if (have_prev) begin
        n_checks++;
        if ({outValid, outData, outAddr, outLast} !== {1'b1, prev_dat, prev_addr, prev_last}) begin
          n_fail++;
          $display("FAIL stall_hold: v=%b d=%h a=%h l=%b required 1 %h %h %b",
                   outValid, outData, outAddr, outLast, prev_dat, prev_addr, prev_last);
        end
      end
      r = pat[cyc % 4];
      if (outAddr == 4'd5 && stall5 < 2) begin
        r = 1'b0;
        stall5++;
        if (stall5 == 1) begin
          writeEn = 1'b1; writeAddr = 4'd5; writeData = 8'hFF;
        end
      end
      outReady = r;
      if (r) begin
        n_checks++;
        if ({outValid, outData, outAddr, outLast} !==
            {1'b1, 8'(8'h10 + nbeats), 4'(nbeats), (nbeats == N - 1)}) begin
          n_fail++;
          $display("FAIL stall_beat%0d: v=%b d=%h a=%h l=%b", nbeats, outValid, outData, outAddr, outLast);
        end
        nbeats++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev_dat = outData; prev_addr = outAddr; prev_last = outLast;
      end
      @(negedge clk);
    end
    writeEn = 1'b0; outReady = 1'b1;
    n_checks++;
    if (nbeats != N || {outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_count: beats=%0d valid/busy=%b required %0d 00", nbeats, {outValid, busy}, N);
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_d;
    @(negedge clk);
    dumpReq = 1'b1; readReq = 1'b1; readAddr = 4'd3; outReady = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_d = (i == 5) ? 8'hFF : 8'(8'h10 + i);
      n_checks++;
      if ({outValid, outData, outAddr, outLast} !== {1'b1, exp_d, 4'(i), (i == N - 1)}) begin
        n_fail++;
        $display("FAIL prio_beat%0d: v=%b d=%h a=%h l=%b required d=%h", i, outValid, outData, outAddr,
                 outLast, exp_d);
      end
      if (i == N - 1) readReq = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_no_single: valid/busy=%b required 00", {outValid, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL prio_idle: valid/busy=%b required 00", {outValid, busy});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    readReq = 1'b1; readAddr = 4'd3; outReady = 1'b1;
    @(negedge clk);
    readReq = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr, outLast} !== {1'b1, 8'h13, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_first: v=%b d=%h a=%h l=%b required 1 13 3 1", outValid, outData, outAddr, outLast);
    end
`ifdef REGISTER_READER_PARITY_EN
    n_checks++;
    if (outParity !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_parity: %b required 1", outParity);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: outValid=%b required 0", outValid);
    end
    readReq = 1'b1; readAddr = 4'd5;
    @(negedge clk);
    readReq = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr, outLast} !== {1'b1, 8'hFF, 4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_second: v=%b d=%h a=%h l=%b required 1 ff 5 1", outValid, outData, outAddr, outLast);
    end
    @(negedge clk);
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_done: valid/busy=%b required 00", {outValid, busy});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    writeEn = 1'b1; writeAddr = 4'd2; writeData = 8'h33;
    @(negedge clk);
    writeEn = 1'b0; dumpReq = 1'b1; outReady = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if ({outValid, outAddr} !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL rstmid_beat7: v=%b a=%h required 1 7", outValid, outAddr);
    end
    rstN = 1'b0; writeEn = 1'b1; writeAddr = 4'd4; writeData = 8'h77;
    @(negedge clk);
    rstN = 1'b1; writeEn = 1'b0;
    n_checks++;
    if ({outValid, busy, outData} !== {2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_abort: v=%b b=%b d=%h required 0 0 00", outValid, busy, outData);
    end
    @(negedge clk);
    n_checks++;
    if (outValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nobeat: outValid=%b required 0", outValid);
    end
    readReq = 1'b1; readAddr = 4'd2;
    @(negedge clk);
    readReq = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr} !== {1'b1, 8'h00, 4'd2}) begin
      n_fail++;
      $display("FAIL rstmid_reg2: v=%b d=%h a=%h required 1 00 2", outValid, outData, outAddr);
    end
    @(negedge clk);
    readReq = 1'b1; readAddr = 4'd4;
    @(negedge clk);
    readReq = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr} !== {1'b1, 8'h00, 4'd4}) begin
      n_fail++;
      $display("FAIL rstmid_reg4: v=%b d=%h a=%h required 1 00 4", outValid, outData, outAddr);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    @(negedge clk);
    writeEn = 1'b1; writeAddr = 4'd0; writeData = 8'h5A; dumpReq = 1'b1; outReady = 1'b0;
    @(negedge clk);
    dumpReq = 1'b0; writeData = 8'h11;
    n_checks++;
    if ({outValid, outData, outAddr, outLast} !== {1'b1, 8'h5A, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL bypass_first: v=%b d=%h a=%h l=%b required 1 5a 0 0", outValid, outData, outAddr, outLast);
    end
`ifdef REGISTER_READER_PARITY_EN
    n_checks++;
    if (outParity !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_parity: %b required 0", outParity);
    end
`endif
    @(negedge clk);
    writeEn = 1'b0;
    n_checks++;
    if ({outValid, outData, outAddr} !== {1'b1, 8'h5A, 4'd0}) begin
      n_fail++;
      $display("FAIL bypass_hold: v=%b d=%h a=%h required 1 5a 0", outValid, outData, outAddr);
    end
    outReady = 1'b1;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      n_checks++;
      if ({outValid, outData, outAddr, outLast} !== {1'b1, 8'h00, 4'(i), (i == N - 1)}) begin
        n_fail++;
        $display("FAIL bypass_beat%0d: v=%b d=%h a=%h l=%b", i, outValid, outData, outAddr, outLast);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({outValid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL bypass_done: valid/busy=%b required 00", {outValid, busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dump();
    test_stall();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
